// File: rtl/param_reservation_station.sv
// Parametrised reservation station: one instance per functional unit.
// Holds renamed ops until both source operands are available, snoops NUM_CDB
// broadcast buses for wakeup, and issues the oldest ready entry to the
// functional unit through a valid/ready handshake. A flush squashes every entry.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               squash all entries at the next edge
//   alloc_*             dispatch interface; alloc_ready = a free entry exists
//   cdb_valid, cdb_pd   per-channel wakeup broadcasts
//   issue_*             oldest ready entry presented to the functional unit
//   occupancy           registered count of busy entries
module param_reservation_station #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NUM_CDB   = 2,
  parameter int unsigned PREG_W    = 7,
  parameter int unsigned ROB_W     = 6,
  parameter int unsigned PAYLOAD_W = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        alloc_valid,
  output logic                        alloc_ready,
  input  logic [PREG_W-1:0]           alloc_ps1,
  input  logic                        alloc_ps1_v,
  input  logic [PREG_W-1:0]           alloc_ps2,
  input  logic                        alloc_ps2_v,
  input  logic [PREG_W-1:0]           alloc_pd,
  input  logic [ROB_W-1:0]            alloc_rob,
  input  logic [PAYLOAD_W-1:0]        alloc_payload,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*PREG_W-1:0]   cdb_pd,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [PREG_W-1:0]           issue_ps1,
  output logic [PREG_W-1:0]           issue_ps2,
  output logic [PREG_W-1:0]           issue_pd,
  output logic [ROB_W-1:0]            issue_rob,
  output logic [PAYLOAD_W-1:0]        issue_payload,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]     busy_q, busy_d;
  logic [DEPTH-1:0]     ps1_v_q, ps1_v_d, ps2_v_q, ps2_v_d;
  // older_q[i][j] = entry i was allocated before entry j
  logic [DEPTH-1:0]     older_q [DEPTH];
  logic [DEPTH-1:0]     older_d [DEPTH];
  logic [OccW-1:0]      occ_q, occ_d;

  logic [PREG_W-1:0]    ps1_q [DEPTH];
  logic [PREG_W-1:0]    ps2_q [DEPTH];
  logic [PREG_W-1:0]    pd_q  [DEPTH];
  logic [ROB_W-1:0]     rob_q [DEPTH];
  logic [PAYLOAD_W-1:0] pay_q [DEPTH];

  logic [DEPTH-1:0]     ready, sel, alloc_oh;
  logic                 alloc_fire, issue_fire;

  function automatic logic cdb_hit(input logic [PREG_W-1:0]         preg,
                                   input logic [NUM_CDB-1:0]        v,
                                   input logic [NUM_CDB*PREG_W-1:0] pd);
    cdb_hit = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (v[k] && (pd[k*PREG_W +: PREG_W] == preg)) cdb_hit = 1'b1;
    end
  endfunction

  assign alloc_ready = ~(&busy_q);
  assign occupancy   = occ_q;
  // Lowest zero bit of busy_q.
  assign alloc_oh    = ~busy_q & (busy_q + DEPTH'(1));
  assign alloc_fire  = alloc_valid & alloc_ready & ~flush;

  // Oldest-ready select and issue mux.
  always_comb begin
    ready         = busy_q & ps1_v_q & ps2_v_q;
    sel           = '0;
    issue_ps1     = '0;
    issue_ps2     = '0;
    issue_pd      = '0;
    issue_rob     = '0;
    issue_payload = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (ready[j] && older_q[j][i]) sel[i] = 1'b0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        issue_ps1     = ps1_q[i];
        issue_ps2     = ps2_q[i];
        issue_pd      = pd_q[i];
        issue_rob     = rob_q[i];
        issue_payload = pay_q[i];
      end
    end
    issue_valid = |ready;
    issue_fire  = issue_valid & issue_ready;
  end

  // Next-state for busy, operand-valid bits, age matrix and occupancy.
  always_comb begin
    busy_d = busy_q;
    if (issue_fire) busy_d = busy_d & ~sel;
    for (int i = 0; i < DEPTH; i++) begin
      older_d[i] = older_q[i];
      ps1_v_d[i] = ps1_v_q[i] | cdb_hit(ps1_q[i], cdb_valid, cdb_pd);
      ps2_v_d[i] = ps2_v_q[i] | cdb_hit(ps2_q[i], cdb_valid, cdb_pd);
    end
    if (alloc_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_oh[i]) begin
          busy_d[i]  = 1'b1;
          // Same-cycle bypass so a broadcast during allocation is not lost.
          ps1_v_d[i] = alloc_ps1_v | cdb_hit(alloc_ps1, cdb_valid, cdb_pd);
          ps2_v_d[i] = alloc_ps2_v | cdb_hit(alloc_ps2, cdb_valid, cdb_pd);
          older_d[i] = '0;
          for (int j = 0; j < DEPTH; j++) older_d[j][i] = busy_q[j];
        end
      end
    end
    if (flush) busy_d = '0;
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) occ_d = occ_d + OccW'(busy_d[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      ps1_v_q <= '0;
      ps2_v_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else begin
      busy_q  <= busy_d;
      ps1_v_q <= ps1_v_d;
      ps2_v_q <= ps2_v_d;
      occ_q   <= occ_d;
      for (int i = 0; i < DEPTH; i++) older_q[i] <= older_d[i];
    end
  end

  // Entry payload storage; only meaningful while the entry is busy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_fire && alloc_oh[i]) begin
        ps1_q[i] <= alloc_ps1;
        ps2_q[i] <= alloc_ps2;
        pd_q[i]  <= alloc_pd;
        rob_q[i] <= alloc_rob;
        pay_q[i] <= alloc_payload;
      end
    end
  end

endmodule

// File: doc/param_reservation_station.md
Name: param_reservation_station

Overview:
- Generic, parametrised reservation station for the out-of-order core; replaces the fixed 4-entry per-unit stations (add/mul/div/mem/branch) with one block instantiated per functional unit.
- Accepts renamed ops from dispatch and snoops NUM_CDB result buses to wake up source operands.
- Issues the oldest ready entry to its functional unit with a valid/ready handshake; supports a full flush on branch mispredict.

Parameters:
DEPTH, 4, number of entries (2..16)
NUM_CDB, 2, number of CDB wakeup channels (1..4)
PREG_W, 7, physical register index width
ROB_W, 6, ROB index width
PAYLOAD_W, 64, opaque payload width (decoded fields, passed through unchanged)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  squash all entries
alloc_valid  in  1  dispatch presents an op
alloc_ready  out  1  at least one free entry
alloc_ps1  in  PREG_W  source 1 physical reg
alloc_ps1_v  in  1  source 1 already available
alloc_ps2  in  PREG_W  source 2 physical reg
alloc_ps2_v  in  1  source 2 already available
alloc_pd  in  PREG_W  destination physical reg
alloc_rob  in  ROB_W  ROB index
alloc_payload  in  PAYLOAD_W  opaque payload
cdb_valid  in  NUM_CDB  per-channel broadcast valid
cdb_pd  in  NUM_CDB*PREG_W  per-channel produced physical reg, channel k at bits [k*PREG_W +: PREG_W]
issue_valid  out  1  a ready entry is presented
issue_ready  in  1  functional unit accepts
issue_ps1  out  PREG_W  selected entry source 1
issue_ps2  out  PREG_W  selected entry source 2
issue_pd  out  PREG_W  selected entry destination
issue_rob  out  ROB_W  selected entry ROB index
issue_payload  out  PAYLOAD_W  selected entry payload
occupancy  out  $clog2(DEPTH+1)  busy entry count

Behaviour:
- Reset (async, rst_n low): all entries not busy, age matrix cleared.
- Reset output values: alloc_ready=1, issue_valid=0, occupancy=0. issue_* data fields are don't-care while issue_valid=0.
- Per-entry state: busy, ps1, ps1_v, ps2, ps2_v, pd, rob, payload.
- Age: DEPTH x DEPTH age matrix; older[i][j]=1 means entry i was allocated before entry j.
- Allocation:
  - Occurs when alloc_valid && alloc_ready. alloc_ready = !(all entries busy); it does not depend on issue that cycle (no comb path from issue_ready).
  - Target is the lowest-index free entry.
  - The new entry is marked younger than all busy entries.
- Wakeup:
  - Every edge, for each busy entry and source s: if any channel k has cdb_valid[k] && cdb_pd[k]==ps_s, set ps_s_v=1.
  - The allocating op also compares against the same-cycle CDB. Stored ps_v = alloc_ps_v | match, so no wakeup is lost.
- Ready/select:
  - ready_i = busy & ps1_v & ps2_v, from registered state only. Earliest issue is the cycle after wakeup; allocation-to-issue minimum is 1 cycle.
  - Selected = ready entry with no older ready entry.
  - issue_valid = any ready; issue_* are combinational from the selected entry.
- Issue handshake:
  - On issue_valid && issue_ready, the selected entry's busy clears at the edge.
  - While issue_ready=0, the presented entry may change only if an older entry becomes ready; the data is stable otherwise.
- Simultaneous events:
  - Issue and allocation in the same cycle are both performed. The freed slot is reusable from the next cycle.
  - Multiple CDB channels matching the same register are harmless (OR).
- Flush: synchronous; all busy cleared at the edge. Flush overrides the same-cycle alloc and issue, so no new entry is written and occupancy becomes 0.
- occupancy: registered popcount of busy; it never exceeds DEPTH.

Test Plan:
- Reset with rst_n=0 asserted mid-cycle -> issue_valid=0, alloc_ready=1, occupancy=0 immediately, without waiting for a clock edge.
- Alloc rob=3 with ps1=5 (v=0), ps2=6 (v=1); next cycle cdb_valid=01, cdb_pd[0]=5 -> issue_valid=1 the following cycle, issue_rob=3, issue_pd echoed.
- Same-cycle bypass: alloc ps1=9 (v=0) while cdb_valid=10, cdb_pd[1]=9 -> entry issues next cycle, with no further broadcast needed.
- Fill DEPTH=4 with rob=0..3, all operands valid, issue_ready=0 -> alloc_ready=0, occupancy=4, issue_rob=0. Raise issue_ready -> issue order 0,1,2,3. Re-allocate rob=4 into freed slot 0 -> it issues after rob=3 (age, not index).
- Full station with issue accepted and alloc_valid in the same cycle -> alloc_ready=0 that cycle, so the alloc is not accepted. The next cycle the alloc is accepted and occupancy returns to 4.
- With 3 entries busy, assert flush together with alloc_valid and issue_ready -> next cycle occupancy=0, issue_valid=0, and the flushed alloc is not present.
